// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt vector responder: FSM state encoding,
// vector width and a lowest-set-bit selector used by the priority encoder.
package irq_pkg;

    localparam int IRQ_VEC_W = 8;
    localparam int IRQ_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [IRQ_IDX_W-1:0] idx;
    } sel_t;

    // Bit 0 has the highest priority, so the lowest set index wins.
    function automatic sel_t lowest_set_idx(input logic [IRQ_VEC_W-1:0] vec);
        sel_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int i = IRQ_VEC_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.valid = 1'b1;
                r.idx   = IRQ_IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/interrupt_vector_responder_if.sv
// CPU-side interrupt acknowledge bus: M1/IORQ from the CPU, INT and vector data back.
interface interrupt_vector_responder_if;

    logic                          notM1;
    logic                          notIORQ;
    logic                          notINT;
    logic [irq_pkg::IRQ_VEC_W-1:0] Dout;
    logic                          Dout_En;

    modport master (
        output notM1,
        output notIORQ,
        input  notINT,
        input  Dout,
        input  Dout_En
    );

    modport slave (
        input  notM1,
        input  notIORQ,
        output notINT,
        output Dout,
        output Dout_En
    );

endinterface

// File: rtl/irq_priority_encoder.sv
// Picks the lowest set index of a request vector (index 0 = highest priority).
module irq_priority_encoder
    import irq_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic [N_IRQ-1:0]     vec,
    output logic                 valid,
    output logic [IRQ_IDX_W-1:0] idx
);

    sel_t sel;

    always_comb sel = lowest_set_idx(IRQ_VEC_W'(vec));

    assign valid = sel.valid;
    assign idx   = sel.idx;

endmodule

// File: rtl/interrupt_vector_responder.sv
// Peripheral-side responder for the CPU interrupt-acknowledge sequence.
// Define NESTED_IRQ_EN to let higher-priority sources nest over in-service ones.
module interrupt_vector_responder
    import irq_pkg::*;
#(
    parameter int                   N_IRQ        = 8,
    parameter logic [IRQ_VEC_W-1:0] VECTOR_BASE  = 8'h40,
    parameter logic [IRQ_VEC_W-1:0] SPURIOUS_VEC = 8'hFE
) (
    input  logic                         CLK,
    input  logic                         notRESET,
    input  logic [N_IRQ-1:0]             IRQ,
    input  logic                         MASK_WE,
    input  logic [N_IRQ-1:0]             MASK_D,
    input  logic                         EOI,
    interrupt_vector_responder_if.slave  bus,
    output logic [N_IRQ-1:0]             ISR
);

    state_t               state, state_nxt;
    logic [N_IRQ-1:0]     irq_prev, pending, mask;
    logic [N_IRQ-1:0]     blocked, eligible, take_oh, eoi_oh;
    logic [IRQ_VEC_W-1:0] dout_q, dout_nxt;
    logic                 win_valid, isr_valid, ack_strobe, take;
    logic [IRQ_IDX_W-1:0] win_idx, isr_idx;

    assign ack_strobe = !bus.notM1 && !bus.notIORQ;

`ifdef NESTED_IRQ_EN
    always_comb begin
        blocked = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            blocked[i] = isr_valid && (IRQ_IDX_W'(i) >= isr_idx);
        end
    end
`else
    assign blocked = {N_IRQ{isr_valid}};
`endif

    assign eligible = pending & ~mask & ~blocked;

    irq_priority_encoder #(.N_IRQ(N_IRQ)) u_win_enc (
        .vec   (eligible),
        .valid (win_valid),
        .idx   (win_idx)
    );

    irq_priority_encoder #(.N_IRQ(N_IRQ)) u_isr_enc (
        .vec   (ISR),
        .valid (isr_valid),
        .idx   (isr_idx)
    );

    assign take_oh = take ? (N_IRQ'(1) << win_idx) : '0;
    assign eoi_oh  = (EOI && isr_valid) ? (N_IRQ'(1) << isr_idx) : '0;

    always_comb begin
        state_nxt = state;
        dout_nxt  = dout_q;
        take      = 1'b0;
        unique case (state)
            IDLE: begin
                if (ack_strobe) begin
                    state_nxt = ACK;
                    dout_nxt  = SPURIOUS_VEC;
                end else if (win_valid) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (ack_strobe) begin
                    state_nxt = ACK;
                    if (win_valid) begin
                        take     = 1'b1;
                        dout_nxt = VECTOR_BASE | IRQ_VEC_W'({win_idx, 1'b0});
                    end else begin
                        dout_nxt = SPURIOUS_VEC;
                    end
                end else if (!win_valid) begin
                    state_nxt = IDLE;
                end
            end
            ACK: begin
                if (bus.notIORQ) begin
                    dout_nxt  = '0;
                    state_nxt = win_valid ? REQ : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                dout_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) state <= IDLE;
        else           state <= state_nxt;
    end

    // A new edge on the acknowledged bit is OR'd in after the clear, so it stays pending.
    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            irq_prev <= '0;
            pending  <= '0;
            mask     <= '1;
            ISR      <= '0;
            dout_q   <= '0;
        end else begin
            irq_prev <= IRQ;
            pending  <= (pending & ~take_oh) | (IRQ & ~irq_prev);
            ISR      <= (ISR & ~eoi_oh) | take_oh;
            dout_q   <= dout_nxt;
            if (MASK_WE) mask <= MASK_D;
        end
    end

    assign bus.notINT  = (state != REQ);
    assign bus.Dout_En = (state == ACK);
    assign bus.Dout    = dout_q;

endmodule
